// File: rtl/cascade_flex_counter_pkg.sv
// Shared types for the cascaded flexible counter.
// Wrap-mode encodings and a helper that folds the reserved code onto wrap-to-zero.
// No logic state lives here.
package cascade_flex_counter_pkg;

    typedef enum logic [1:0] {
        WRAP_ZERO = 2'b00,
        WRAP_ONE  = 2'b01,
        SATURATE  = 2'b10
    } wrap_mode_t;

    // Encoding 2'b11 is reserved and behaves exactly like WRAP_ZERO.
    localparam logic [1:0] WRAP_RSVD = 2'b11;

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == WRAP_RSVD) ? WRAP_ZERO : m;
    endfunction

endpackage

// File: rtl/flex_counter_ch.sv
// One flexible counter channel: clear > load > count > hold, with per-cycle rollover and wrap mode.
// Count, flag and wrap_pulse are registered (1 cycle); wrap_ev and flag_nxt are combinational.
// No backpressure; the channel advances only when en is high.
module flex_counter_ch
    import cascade_flex_counter_pkg::*;
#(
    parameter int CNT_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clear,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_val,
    input  logic [CNT_BITS-1:0] rollover_val,
    input  logic [1:0]          mode,
    output logic [CNT_BITS-1:0] count,
    output logic                flag,
    output logic                wrap_ev,
    output logic                wrap_pulse,
    output logic                flag_nxt
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [CNT_BITS-1:0] count_q, count_d;
    logic                flag_q, flag_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic [1:0]          mode_n;
    logic                at_term;

    // Next-state: a wrap event is suppressed whenever clear or load takes the channel.
    always_comb begin
        mode_n       = norm_mode(mode);
        at_term      = (count_q == rollover_val);
        wrap_ev      = en & at_term & (mode_n != SATURATE) & ~clear & ~load;
        count_d      = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (at_term) begin
                case (mode_n)
                    WRAP_ONE: count_d = CNT_ONE;
                    SATURATE: count_d = count_q;
                    default:  count_d = '0;
                endcase
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end
        flag_d       = ~clear & (count_d == rollover_val);
        wrap_pulse_d = wrap_ev;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            flag_q       <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            flag_q       <= flag_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign count      = count_q;
    assign flag       = flag_q;
    assign wrap_pulse = wrap_pulse_q;
    assign flag_nxt   = flag_d;

endmodule

// File: rtl/cascade_flex_counter.sv
// NUM_CH flexible counters; with CASCADE, channel i steps only on channel i-1's wrap event.
// All outputs registered, 1-cycle latency; the cascade is one combinational chain so all wraps align.
// No backpressure; per-channel count_enable gates advancement.
module cascade_flex_counter
    import cascade_flex_counter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_BITS = 10,
    parameter bit CASCADE  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            clear,
    input  logic [NUM_CH-1:0]            load,
    input  logic [NUM_CH*CNT_BITS-1:0]   load_val,
    input  logic [NUM_CH-1:0]            count_enable,
    input  logic [NUM_CH*CNT_BITS-1:0]   rollover_val,
    input  logic [2*NUM_CH-1:0]          wrap_mode,
    output logic [NUM_CH*CNT_BITS-1:0]   count_out,
    output logic [NUM_CH-1:0]            rollover_flag,
    output logic [NUM_CH-1:0]            wrap_pulse,
    output logic                         all_terminal
);

    logic [NUM_CH-1:0] flag_nxt_v;
    logic [NUM_CH-1:0] wrap_ev_v;
    logic              all_terminal_q;
    logic              unused_wrap_ev;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic en;
        logic wrap_ev;
        logic flag_nxt;

        if (CASCADE && (gi > 0)) begin : g_casc
            assign en = count_enable[gi] & g_ch[gi-1].wrap_ev;
        end else begin : g_ind
            assign en = count_enable[gi];
        end

        flex_counter_ch #(
            .CNT_BITS (CNT_BITS)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .clear        (clear[gi]),
            .load         (load[gi]),
            .load_val     (load_val[gi*CNT_BITS +: CNT_BITS]),
            .rollover_val (rollover_val[gi*CNT_BITS +: CNT_BITS]),
            .mode         (wrap_mode[2*gi +: 2]),
            .count        (count_out[gi*CNT_BITS +: CNT_BITS]),
            .flag         (rollover_flag[gi]),
            .wrap_ev      (wrap_ev),
            .wrap_pulse   (wrap_pulse[gi]),
            .flag_nxt     (flag_nxt)
        );

        assign flag_nxt_v[gi] = flag_nxt;
        assign wrap_ev_v[gi]  = wrap_ev;
    end

    // The last channel's wrap event has no consumer.
    assign unused_wrap_ev = ^wrap_ev_v;

    // all_terminal is formed from next-state flags so it lines up with rollover_flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            all_terminal_q <= 1'b0;
        end else begin
            all_terminal_q <= &flag_nxt_v;
        end
    end

    assign all_terminal = all_terminal_q;

endmodule

// File: tb/tb_cascade_flex_counter.sv
module tb_cascade_flex_counter;

    localparam int NUM_CH   = 2;
    localparam int CNT_BITS = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_CH-1:0]          clear;
    logic [NUM_CH-1:0]          load;
    logic [NUM_CH*CNT_BITS-1:0] load_val;
    logic [NUM_CH-1:0]          count_enable;
    logic [NUM_CH*CNT_BITS-1:0] rollover_val;
    logic [2*NUM_CH-1:0]        wrap_mode;
    logic [NUM_CH*CNT_BITS-1:0] count_out;
    logic [NUM_CH-1:0]          rollover_flag;
    logic [NUM_CH-1:0]          wrap_pulse;
    logic                       all_terminal;

    int n_checks = 0;
    int n_errors = 0;

    int seq_m00 [7]  = '{1, 2, 3, 4, 5, 0, 1};
    int seq_m01 [6]  = '{1, 2, 3, 1, 2, 3};
    int seq_m10 [5]  = '{1, 2, 3, 3, 3};
    int casc_c0 [6]  = '{1, 2, 0, 1, 2, 0};
    int casc_c1 [6]  = '{0, 0, 1, 1, 1, 0};
    int seq_ld  [10] = '{13, 14, 15, 0, 1, 2, 3, 4, 5, 0};

    cascade_flex_counter #(
        .NUM_CH   (NUM_CH),
        .CNT_BITS (CNT_BITS),
        .CASCADE  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .load          (load),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .rollover_val  (rollover_val),
        .wrap_mode     (wrap_mode),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .wrap_pulse    (wrap_pulse),
        .all_terminal  (all_terminal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        clear        = '0;
        load         = '0;
        load_val     = '0;
        count_enable = '0;
        rollover_val = '0;
        wrap_mode    = '0;

        // Reset for two cycles
        step();
        step();
        chk("rst_count",   32'(count_out),     0);
        chk("rst_flag",    32'(rollover_flag), 0);
        chk("rst_pulse",   32'(wrap_pulse),    0);
        chk("rst_allterm", 32'(all_terminal),  0);

        // Mode 00, rollover 5 on ch0
        rst          = 1'b0;
        rollover_val = {4'd15, 4'd5};
        wrap_mode    = 4'b0000;
        count_enable = 2'b01;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("m00_cnt[%0d]", k),   32'(count_out[3:0]),  seq_m00[k]);
            chk($sformatf("m00_flag[%0d]", k),  32'(rollover_flag[0]), (seq_m00[k] == 5) ? 1 : 0);
            chk($sformatf("m00_pulse[%0d]", k), 32'(wrap_pulse[0]),    (k == 5) ? 1 : 0);
        end
        chk("m00_allterm", 32'(all_terminal), 0);

        // Mode 01, rollover 3
        clear        = 2'b01;
        count_enable = 2'b00;
        step();
        chk("clr_a", 32'(count_out[3:0]), 0);
        clear        = 2'b00;
        rollover_val = {4'd15, 4'd3};
        wrap_mode    = 4'b0001;
        count_enable = 2'b01;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("m01_cnt[%0d]", k),   32'(count_out[3:0]), seq_m01[k]);
            chk($sformatf("m01_pulse[%0d]", k), 32'(wrap_pulse[0]),   (k == 3) ? 1 : 0);
        end

        // Mode 10 (saturate), rollover 3
        clear        = 2'b01;
        count_enable = 2'b00;
        step();
        clear        = 2'b00;
        wrap_mode    = 4'b0010;
        count_enable = 2'b01;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("m10_cnt[%0d]", k),   32'(count_out[3:0]),  seq_m10[k]);
            chk($sformatf("m10_flag[%0d]", k),  32'(rollover_flag[0]), (seq_m10[k] == 3) ? 1 : 0);
            chk($sformatf("m10_pulse[%0d]", k), 32'(wrap_pulse[0]),    0);
        end

        // Cascade: ch0 rollover 2, ch1 rollover 1
        clear        = 2'b11;
        count_enable = 2'b00;
        rollover_val = {4'd1, 4'd2};
        wrap_mode    = 4'b0000;
        step();
        chk("casc_clr", 32'(count_out), 0);
        clear        = 2'b00;
        count_enable = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("casc_c0[%0d]", k), 32'(count_out[3:0]), casc_c0[k]);
            chk($sformatf("casc_c1[%0d]", k), 32'(count_out[7:4]), casc_c1[k]);
            chk($sformatf("casc_at[%0d]", k), 32'(all_terminal), (k == 4) ? 1 : 0);
            chk($sformatf("casc_pl[%0d]", k), 32'(wrap_pulse),
                (k == 5) ? 3 : ((k == 2) ? 1 : 0));
        end

        // Clear + load on ch0 at terminal count 4 must not advance ch1
        clear        = 2'b11;
        count_enable = 2'b00;
        rollover_val = {4'd1, 4'd4};
        step();
        clear        = 2'b00;
        count_enable = 2'b01;
        for (int k = 0; k < 4; k++) step();
        chk("cl_pre_cnt",  32'(count_out[3:0]),  4);
        chk("cl_pre_flag", 32'(rollover_flag[0]), 1);
        clear        = 2'b01;
        load         = 2'b01;
        load_val     = {4'd0, 4'd9};
        count_enable = 2'b11;
        step();
        chk("cl_cnt0",  32'(count_out[3:0]),  0);
        chk("cl_flag0", 32'(rollover_flag[0]), 0);
        chk("cl_cnt1",  32'(count_out[7:4]),  0);
        chk("cl_pulse", 32'(wrap_pulse),      0);

        // Load 12 above rollover 5, count through 15 -> 0 -> 5 -> 0
        clear        = 2'b00;
        load         = 2'b01;
        load_val     = {4'd0, 4'd12};
        count_enable = 2'b00;
        rollover_val = {4'd1, 4'd5};
        step();
        chk("ld_cnt", 32'(count_out[3:0]), 12);
        load         = 2'b00;
        count_enable = 2'b01;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("ld_cnt[%0d]", k),   32'(count_out[3:0]),  seq_ld[k]);
            chk($sformatf("ld_flag[%0d]", k),  32'(rollover_flag[0]), (seq_ld[k] == 5) ? 1 : 0);
            chk($sformatf("ld_pulse[%0d]", k), 32'(wrap_pulse[0]),    (k == 9) ? 1 : 0);
        end

        // Rollover 0: mode 00 stays at 0, mode 01 walks upward
        rollover_val = {4'd1, 4'd0};
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("r0_cnt[%0d]", k),   32'(count_out[3:0]),  0);
            chk($sformatf("r0_flag[%0d]", k),  32'(rollover_flag[0]), 1);
            chk($sformatf("r0_pulse[%0d]", k), 32'(wrap_pulse[0]),    1);
        end
        wrap_mode = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("r0m1_cnt[%0d]", k),  32'(count_out[3:0]),  k + 1);
            chk($sformatf("r0m1_flag[%0d]", k), 32'(rollover_flag[0]), 0);
        end

        // Reset mid-count overrides clear/load
        rollover_val = {4'd1, 4'd5};
        wrap_mode    = 4'b0000;
        clear        = 2'b11;
        count_enable = 2'b00;
        step();
        clear        = 2'b00;
        count_enable = 2'b11;
        step();
        step();
        chk("pre_rst_cnt", 32'(count_out[3:0]), 2);
        rst      = 1'b1;
        clear    = 2'b11;
        load     = 2'b11;
        load_val = 8'hAB;
        step();
        chk("mrst_count", 32'(count_out),     0);
        chk("mrst_flag",  32'(rollover_flag), 0);
        chk("mrst_pulse", 32'(wrap_pulse),    0);
        chk("mrst_at",    32'(all_terminal),  0);
        rst          = 1'b0;
        clear        = 2'b00;
        load         = 2'b00;
        count_enable = 2'b01;
        step();
        chk("post_rst_c0a", 32'(count_out[3:0]), 1);
        chk("post_rst_c1",  32'(count_out[7:4]), 0);
        step();
        chk("post_rst_c0b", 32'(count_out[3:0]), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cascade_flex_counter.md
# cascade_flex_counter

Parametrised multi-channel flexible counter for the edge-detector datapath: NUM_CH independent counters, each with its own rollover value and wrap mode. Each channel also supports synchronous load and optional cascading, where channel i advances only when channel i-1 wraps. Pixel/row/frame address generators and window-position trackers instantiate it in place of chained single-channel counters, so one block produces column, row and frame counts with aligned flags.

## Interface
- NUM_CH, 2, number of counter channels (≥1)
- CNT_BITS, 10, width of each channel's count
- CASCADE, 1, 1 = channel i>0 gated by channel i-1 wrap event; 0 = all independent
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- clear  in  NUM_CH  per-channel synchronous clear
- load  in  NUM_CH  per-channel synchronous load
- load_val  in  NUM_CH*CNT_BITS  load values, channel i at [i*CNT_BITS +: CNT_BITS]
- count_enable  in  NUM_CH  per-channel enable
- rollover_val  in  NUM_CH*CNT_BITS  terminal values, same packing
- wrap_mode  in  2*NUM_CH  per channel: 00 wrap to 0, 01 wrap to 1, 10 saturate, 11 treated as 00
- count_out  out  NUM_CH*CNT_BITS  registered counts, same packing
- rollover_flag  out  NUM_CH  registered; high while count == rollover_val
- wrap_pulse  out  NUM_CH  registered one-cycle pulse, high the cycle after a wrap
- all_terminal  out  1  registered AND of all rollover_flag bits

## Operation
- Per channel, priority: rst > clear > load > count > hold.
- Effective enable en_i: count_enable[i]; with CASCADE=1 and i>0, en_i = count_enable[i] & wrap_ev[i-1] (combinational, same cycle).
- wrap_ev_i = en_i & (count == rollover_val) & mode != saturate; clear or load on channel i forces wrap_ev_i = 0.
- Count step when en_i: if count == rollover_val → 0 (mode 00/11), 1 (mode 01), hold (mode 10); else count + 1 modulo 2^CNT_BITS.
- rollover_val below current count: count runs up through 2^CNT_BITS−1, wraps to 0, then reaches rollover_val normally.
- rollover_val = 0, mode 00: count stays 0, flag stays high, wrap_ev every enabled cycle.
- rollover_val = 0, mode 01: 0 → 1 → … → 2^CNT_BITS−1 → 0 → 1 (flag high only at 0).
- load takes load_val verbatim; values above rollover_val are legal and behave as in the previous rule.
- rollover_flag next = (next_count == rollover_val); clear forces next_flag = 0 regardless of rollover_val.
- wrap_pulse next = wrap_ev_i.
- rollover_val and wrap_mode may change any cycle; they take effect in the same cycle's next-state computation.

## Timing
- Reset: all counts 0, rollover_flag 0, wrap_pulse 0, all_terminal 0 on the first rising edge with rst=1. rst mid-count overrides every other input.
- Latency: counts, flags and pulse update one cycle after the enabling edge; all_terminal is computed from next-state flags, so it has the same latency as the flags.
- Cascade is one combinational chain, NUM_CH deep. There is no extra latency: all channels wrap on the same edge.
- clear and load are single-cycle effective. Holding either asserted keeps the channel at 0 / load_val.

## Structure
- Package cascade_flex_counter_pkg: wrap_mode_t enum (WRAP_ZERO=2'b00, WRAP_ONE=2'b01, SATURATE=2'b10), localparam for the reserved encoding.
- Sub-module flex_counter_ch: one channel with inputs en, clear, load, load_val, rollover_val, mode. Outputs: count, flag, wrap_ev (combinational), wrap_pulse.
- Top level: generate loop, cascade gating, AND-reduction for all_terminal.

## Test plan
- rst=1 for 2 cycles, then CNT_BITS=4, ch0 rollover 5, mode 00, enabled → count 1,2,3,4,5,0,…; flag high only at 5; wrap_pulse one cycle after 5→0.
- Mode 01, rollover 3 → 1,2,3,1,2,3; mode 10, rollover 3 → 1,2,3,3,3 with flag held high and no wrap_pulse.
- CASCADE=1, ch0 rollover 2, ch1 rollover 1, both enabled → ch1 increments only on ch0 wraps; after 6 enabled cycles both are 0 again; all_terminal is high exactly when the counts are (2,1).
- Simultaneous clear and load on ch0 at count 4 → count 0, flag 0, ch1 not advanced even though count_enable[1]=1.
- load 12 with rollover 5 (CNT_BITS=4) → 13,14,15,0,1,…,5,0; rollover_val=0 in mode 00 → count stays 0, flag high constantly.
- rst asserted mid-count with load=1 and clear=1 → all outputs 0 next cycle; normal counting resumes from 0.
